// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle ALU control sequencer: DECODE/EXEC/MEM/WB/BR around a valid/ready instruction port.
// All outputs are registered and reflect the state being entered, so each state drives its own strobes.
module alu_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic [2:0]  alu_op,
   output logic        alu_src_imm,
   output logic [31:0] imm_ext,
   output logic [3:0]  rs1_addr,
   output logic [3:0]  rs2_addr,
   input  logic        alu_zero,
   input  logic        alu_cmp,
   input  logic        alu_carry,
   input  logic        alu_neg,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ready,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic        wb_sel,
   output logic        pc_load,
   output logic [3:0]  flags_q,
   output logic        done,
   output logic        illegal,
   output logic        bus_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_BR
   } state_t;

   localparam logic [3:0] OP_SRL  = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd6;
   localparam logic [3:0] OP_SW   = 4'd7;
   localparam logic [3:0] OP_BEQ  = 4'd8;
   localparam logic [3:0] OP_BNE  = 4'd9;
   localparam logic [3:0] OP_BLTU = 4'd10;
   localparam logic [3:0] OP_J    = 4'd11;
   localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state;
   logic [31:0] instr_q;
   logic [7:0]  mem_cnt;

   logic [3:0]  op_q;
   logic [3:0]  rd_q;
   logic [2:0]  exec_op;
   logic        exec_src;
   logic        is_mem;
   logic        is_branch;
   logic        br_taken;

   assign op_q      = instr_q[31:28];
   assign rd_q      = instr_q[27:24];
   assign is_mem    = (op_q == OP_LW) || (op_q == OP_SW);
   assign is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE) || (op_q == OP_BLTU);

   always_comb begin
      exec_op  = 3'b000;
      exec_src = 1'b0;
      if (op_q <= OP_SRL) begin
         exec_op = op_q[2:0];
      end else if (op_q <= OP_SW) begin
         exec_op  = 3'b001;
         exec_src = 1'b1;
      end else begin
         exec_op = 3'b010;
      end
   end

   // Evaluated on the edge that ends EXEC, i.e. on exactly the flags flags_q captures there.
   always_comb begin
      br_taken = 1'b0;
      case (op_q)
         OP_BEQ:  br_taken = alu_zero;
         OP_BNE:  br_taken = !alu_zero;
         OP_BLTU: br_taken = alu_cmp;
         default: br_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         instr_q     <= '0;
         mem_cnt     <= '0;
         flags_q     <= '0;
         instr_ready <= 1'b1;
         alu_op      <= '0;
         alu_src_imm <= 1'b0;
         imm_ext     <= '0;
         rs1_addr    <= '0;
         rs2_addr    <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         wb_sel      <= 1'b0;
         pc_load     <= 1'b0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         bus_error   <= 1'b0;
      end else begin
         instr_ready <= 1'b0;
         alu_op      <= '0;
         alu_src_imm <= 1'b0;
         imm_ext     <= '0;
         rs1_addr    <= '0;
         rs2_addr    <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         wb_sel      <= 1'b0;
         pc_load     <= 1'b0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         bus_error   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  instr_q <= instr;
                  state   <= S_DECODE;
                  if (instr[31:30] == 2'b11) begin
                     illegal <= 1'b1;
                  end else begin
                     rs1_addr <= instr[23:20];
                     rs2_addr <= instr[19:16];
                     imm_ext  <= {{16{instr[15]}}, instr[15:0]};
                  end
               end else begin
                  instr_ready <= 1'b1;
               end
            end

            S_DECODE: begin
               if (op_q[3:2] == 2'b11) begin
                  state       <= S_IDLE;
                  instr_ready <= 1'b1;
               end else if (op_q == OP_J) begin
                  state   <= S_BR;
                  pc_load <= 1'b1;
                  done    <= 1'b1;
               end else begin
                  state       <= S_EXEC;
                  alu_op      <= exec_op;
                  alu_src_imm <= exec_src;
                  rs1_addr    <= instr_q[23:20];
                  rs2_addr    <= instr_q[19:16];
                  imm_ext     <= {{16{instr_q[15]}}, instr_q[15:0]};
               end
            end

            S_EXEC: begin
               if (!is_mem) begin
                  flags_q <= {alu_neg, alu_carry, alu_cmp, alu_zero};
               end
               if (is_mem) begin
                  state   <= S_MEM;
                  mem_cnt <= '0;
                  mem_req <= 1'b1;
                  mem_we  <= (op_q == OP_SW);
               end else if (is_branch) begin
                  state   <= S_BR;
                  pc_load <= br_taken;
                  done    <= 1'b1;
               end else begin
                  state    <= S_WB;
                  rf_we    <= 1'b1;
                  rf_waddr <= rd_q;
                  done     <= 1'b1;
               end
            end

            // S_WB doubles as the completion cycle for stores and timeouts, with rf_we left low.
            S_MEM: begin
               if (mem_ready) begin
                  state <= S_WB;
                  done  <= 1'b1;
                  if (op_q == OP_LW) begin
                     rf_we    <= 1'b1;
                     rf_waddr <= rd_q;
                     wb_sel   <= 1'b1;
                  end
               end else if (mem_cnt == CNT_LAST) begin
                  state     <= S_WB;
                  bus_error <= 1'b1;
               end else begin
                  mem_cnt <= mem_cnt + 8'd1;
                  mem_req <= 1'b1;
                  mem_we  <= (op_q == OP_SW);
               end
            end

            S_WB, S_BR: begin
               state       <= S_IDLE;
               instr_ready <= 1'b1;
            end

            default: begin
               state       <= S_IDLE;
               instr_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: a vector table of single instructions plus reset and back-to-back sequences.
module tb_alu_ctrl_fsm;

   localparam int MEM_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [2:0]  alu_op;
   logic        alu_src_imm;
   logic [31:0] imm_ext;
   logic [3:0]  rs1_addr;
   logic [3:0]  rs2_addr;
   logic        alu_zero;
   logic        alu_cmp;
   logic        alu_carry;
   logic        alu_neg;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ready;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic        wb_sel;
   logic        pc_load;
   logic [3:0]  flags_q;
   logic        done;
   logic        illegal;
   logic        bus_error;

   alu_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm_ext(imm_ext),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .alu_zero(alu_zero), .alu_cmp(alu_cmp), .alu_carry(alu_carry), .alu_neg(alu_neg),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .wb_sel(wb_sel),
      .pc_load(pc_load), .flags_q(flags_q),
      .done(done), .illegal(illegal), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // flg is {neg, carry, cmp, zero}; kind is one-hot {bus_error, illegal, done}
   typedef struct {
      logic [31:0] ins;
      logic [3:0]  flg;
      int          mem_wait;
      int          end_cyc;
      logic [2:0]  kind;
      logic [2:0]  aop;
      logic        asrc;
      logic [31:0] imm;
      logic        pcl;
      int          rfw;
      logic [3:0]  waddr;
      logic        wbs;
      int          memreq;
      int          memwe;
      logic [3:0]  flags;
   } vec_t;

   vec_t v[14];

   task automatic run_vec(input int i);
      vec_t t;
      int cyc, memcnt, wecnt, rfcnt, wait_cnt, end_cyc;
      bit end_seen;
      logic [2:0]  kind_s, aop_s;
      logic        asrc_s, pcl_s, wbs_s, rdy_end;
      logic [31:0] imm_s;
      logic [3:0]  waddr_s;
      t = v[i];
      {alu_neg, alu_carry, alu_cmp, alu_zero} = t.flg;
      wait_cnt = 0;
      while (!instr_ready && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      chk($sformatf("v%0d_ready_at_start", i), 32'(instr_ready), 32'd1);
      instr_valid = 1'b1;
      instr = t.ins;
      @(negedge clk);
      instr_valid = 1'b0;
      instr = '0;
      cyc = 1; memcnt = 0; wecnt = 0; rfcnt = 0; end_seen = 0; end_cyc = 0;
      kind_s = '0; aop_s = '0; asrc_s = 0; pcl_s = 0; wbs_s = 0; rdy_end = 0;
      imm_s = '0; waddr_s = '0;
      while (!end_seen && cyc <= 40) begin
         if (cyc == 1) imm_s = imm_ext;
         if (cyc == 2) begin
            aop_s  = alu_op;
            asrc_s = alu_src_imm;
         end
         if (rf_we) rfcnt++;
         if (mem_req) begin
            memcnt++;
            if (mem_we) wecnt++;
         end
         if (done || illegal || bus_error) begin
            end_seen = 1;
            end_cyc  = cyc;
            kind_s   = {bus_error, illegal, done};
            pcl_s    = pc_load;
            waddr_s  = rf_waddr;
            wbs_s    = wb_sel;
            rdy_end  = instr_ready;
         end
         mem_ready = mem_req && (memcnt == t.mem_wait);
         if (!end_seen) begin
            @(negedge clk);
            cyc++;
         end
      end
      mem_ready = 1'b0;
      if (!end_seen) begin
         checks++;
         failures++;
         $display("FAIL v%0d_timeout no completion pulse within 40 cycles", i);
      end
      chk($sformatf("v%0d_end_cycle", i), 32'(end_cyc), 32'(t.end_cyc));
      chk($sformatf("v%0d_pulse_kind", i), 32'(kind_s), 32'(t.kind));
      chk($sformatf("v%0d_pc_load", i), 32'(pcl_s), 32'(t.pcl));
      chk($sformatf("v%0d_rf_we_cycles", i), 32'(rfcnt), 32'(t.rfw));
      chk($sformatf("v%0d_rf_waddr", i), 32'(waddr_s), 32'(t.waddr));
      chk($sformatf("v%0d_wb_sel", i), 32'(wbs_s), 32'(t.wbs));
      chk($sformatf("v%0d_mem_req_cycles", i), 32'(memcnt), 32'(t.memreq));
      chk($sformatf("v%0d_mem_we_cycles", i), 32'(wecnt), 32'(t.memwe));
      chk($sformatf("v%0d_imm_ext", i), imm_s, t.imm);
      chk($sformatf("v%0d_flags_q", i), 32'(flags_q), 32'(t.flags));
      chk($sformatf("v%0d_ready_during_pulse", i), 32'(rdy_end), 32'd0);
      if (t.end_cyc >= 2) begin
         chk($sformatf("v%0d_alu_op", i), 32'(aop_s), 32'(t.aop));
         chk($sformatf("v%0d_alu_src_imm", i), 32'(asrc_s), 32'(t.asrc));
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", i), 32'(instr_ready), 32'd1);
   endtask

   initial begin
      int rfcnt;
      //      ins           flg     mw  end kind    aop     src   imm            pcl  rfw wa    wbs mr  mwe flags
      v[0]  = '{32'h1312_0000, 4'b0101, 0, 3,  3'b001, 3'b001, 1'b0, 32'h0,         1'b0, 1, 4'd3, 1'b0, 0,  0,  4'b0101}; // ADD r3
      v[1]  = '{32'h8045_0010, 4'b0001, 0, 3,  3'b001, 3'b010, 1'b0, 32'h10,        1'b1, 0, 4'd0, 1'b0, 0,  0,  4'b0001}; // BEQ taken
      v[2]  = '{32'h8045_0010, 4'b0010, 0, 3,  3'b001, 3'b010, 1'b0, 32'h10,        1'b0, 0, 4'd0, 1'b0, 0,  0,  4'b0010}; // BEQ not taken
      v[3]  = '{32'h6510_FFFC, 4'b1001, 3, 6,  3'b001, 3'b001, 1'b1, 32'hFFFF_FFFC, 1'b0, 1, 4'd5, 1'b1, 3,  0,  4'b0010}; // LW r5
      v[4]  = '{32'h7023_0008, 4'b1111, 0, 19, 3'b100, 3'b001, 1'b1, 32'h8,         1'b0, 0, 4'd0, 1'b0, 16, 16, 4'b0010}; // SW timeout
      v[5]  = '{32'hC123_4567, 4'b1111, 0, 1,  3'b010, 3'b000, 1'b0, 32'h0,         1'b0, 0, 4'd0, 1'b0, 0,  0,  4'b0010}; // illegal
      v[6]  = '{32'hB000_0100, 4'b1111, 0, 2,  3'b001, 3'b000, 1'b0, 32'h100,       1'b1, 0, 4'd0, 1'b0, 0,  0,  4'b0010}; // J
      v[7]  = '{32'h7023_0004, 4'b0101, 1, 4,  3'b001, 3'b001, 1'b1, 32'h4,         1'b0, 0, 4'd0, 1'b0, 1,  1,  4'b0010}; // SW ok
      v[8]  = '{32'hA012_0000, 4'b0110, 0, 3,  3'b001, 3'b010, 1'b0, 32'h0,         1'b1, 0, 4'd0, 1'b0, 0,  0,  4'b0110}; // BLTU taken
      v[9]  = '{32'h9012_0000, 4'b0001, 0, 3,  3'b001, 3'b010, 1'b0, 32'h0,         1'b0, 0, 4'd0, 1'b0, 0,  0,  4'b0001}; // BNE not taken
      v[10] = '{32'h3712_0000, 4'b1000, 0, 3,  3'b001, 3'b011, 1'b0, 32'h0,         1'b0, 1, 4'd7, 1'b0, 0,  0,  4'b1000}; // SLL r7
      v[11] = '{32'h5210_8000, 4'b0000, 0, 3,  3'b001, 3'b001, 1'b1, 32'hFFFF_8000, 1'b0, 1, 4'd2, 1'b0, 0,  0,  4'b0000}; // ADDI r2
      v[12] = '{32'h9012_0000, 4'b0000, 0, 3,  3'b001, 3'b010, 1'b0, 32'h0,         1'b1, 0, 4'd0, 1'b0, 0,  0,  4'b0000}; // BNE taken
      v[13] = '{32'h4112_0000, 4'b0001, 0, 3,  3'b001, 3'b100, 1'b0, 32'h0,         1'b0, 1, 4'd1, 1'b0, 0,  0,  4'b0001}; // SRL r1

      reset = 1'b1;
      instr_valid = 1'b0;
      instr = '0;
      {alu_neg, alu_carry, alu_cmp, alu_zero} = 4'b0000;
      mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {alu_op, alu_src_imm, imm_ext[15:0], rs1_addr, rs2_addr},
          32'h0);
      chk("reset_ctrl",
          32'({instr_ready, mem_req, mem_we, rf_we, rf_waddr, wb_sel, pc_load, flags_q, done, illegal, bus_error}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}));
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", 32'(instr_ready), 32'd1);

      for (int i = 0; i < 14; i++) run_vec(i);

      // Reset while an LW waits in MEM.
      instr_valid = 1'b1;
      instr = 32'h6510_0000;
      @(negedge clk);
      instr_valid = 1'b0;
      instr = '0;
      repeat (2) @(negedge clk);
      chk("midmem_mem_req_before", 32'(mem_req), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("midmem_mem_req", 32'(mem_req), 32'd0);
      chk("midmem_ready", 32'(instr_ready), 32'd1);
      chk("midmem_flags", 32'(flags_q), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rfcnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rf_we || mem_req || done) rfcnt++;
      end
      chk("midmem_no_activity_after", 32'(rfcnt), 32'd0);

      // Back-to-back J with instr_valid held high.
      instr_valid = 1'b1;
      instr = 32'hB000_0000;
      @(negedge clk);
      chk("b2b_c1_ready", 32'(instr_ready), 32'd0);
      @(negedge clk);
      chk("b2b_c2_pc_load_done", 32'({pc_load, done}), 32'd3);
      @(negedge clk);
      chk("b2b_c3_ready", 32'(instr_ready), 32'd1);
      @(negedge clk);
      instr_valid = 1'b0;
      instr = '0;
      chk("b2b_c4_accepted", 32'(instr_ready), 32'd0);
      @(negedge clk);
      chk("b2b_c5_pc_load", 32'(pc_load), 32'd1);
      @(negedge clk);
      chk("b2b_c6_ready", 32'(instr_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
